// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift opcodes, FLAGS bit positions and shift sequencer states.
package alu_pkg;

  localparam logic [3:0] alu_rol = 4'h8;
  localparam logic [3:0] alu_ror = 4'h9;
  localparam logic [3:0] alu_rcl = 4'hA;
  localparam logic [3:0] alu_rcr = 4'hB;
  localparam logic [3:0] alu_shl = 4'hC;
  localparam logic [3:0] alu_shr = 4'hD;
  localparam logic [3:0] alu_sal = 4'hE;
  localparam logic [3:0] alu_sar = 4'hF;

  localparam int unsigned FLAG_CF = 0;
  localparam int unsigned FLAG_PF = 2;
  localparam int unsigned FLAG_AF = 4;
  localparam int unsigned FLAG_ZF = 6;
  localparam int unsigned FLAG_SF = 7;
  localparam int unsigned FLAG_OF = 11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } seq_state_e;

  // Operand MSB for the selected width.
  function automatic logic msb_sel(input logic [15:0] v, input logic b16);
    return b16 ? v[15] : v[7];
  endfunction

endpackage

// File: rtl/alu_shift_flags.sv
// Combinational flag generator for the final step of a shift/rotate sequence.
module alu_shift_flags
  import alu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic        bit16_i,
  input  logic [15:0] pre_i,
  input  logic [15:0] post_i,
  input  logic        cf_i,
  input  logic [11:0] flags_i,
  output logic [11:0] flags_o
);

  logic post_msb;
  logic post_msb1;
  logic pre_msb;
  logic post_zero;
  logic unused_pre;

  assign unused_pre = ^pre_i;

  always_comb begin
    post_msb  = msb_sel(post_i, bit16_i);
    post_msb1 = bit16_i ? post_i[14] : post_i[6];
    pre_msb   = msb_sel(pre_i, bit16_i);
    post_zero = bit16_i ? (post_i == 16'h0000) : (post_i[7:0] == 8'h00);

    flags_o          = flags_i;
    flags_o[FLAG_CF] = cf_i;
    unique case (op_i)
      3'd0, 3'd2, 3'd4, 3'd6: flags_o[FLAG_OF] = cf_i ^ post_msb;
      3'd1, 3'd3:             flags_o[FLAG_OF] = post_msb ^ post_msb1;
      3'd5:                   flags_o[FLAG_OF] = pre_msb;
      default:                flags_o[FLAG_OF] = 1'b0;
    endcase

    // Rotates leave SF/ZF/PF untouched.
    if (op_i[2]) begin
      flags_o[FLAG_SF] = post_msb;
      flags_o[FLAG_ZF] = post_zero;
      flags_o[FLAG_PF] = ~^post_i[7:0];
    end
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate sequencer driving the shared ALU one bit per cycle.
// Optional rotate count reduction: define ALU_SHIFT_SEQ_ROTRED_EN.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter logic [4:0] CNT_MASK = 5'h1F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        bit16,
  input  logic [7:0]  count,
  input  logic [15:0] op1_in,
  input  logic [11:0] flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [11:0] flags_res,
  output logic        alu_busy,
  output logic [3:0]  alu_sel,
  output logic [15:0] alu_op1,
  output logic        alu_bit16,
  output logic [11:0] alu_flags,
  input  logic [15:0] alu_value
);

  seq_state_e  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        bit16_q, bit16_d;
  logic [15:0] work_q, work_d;
  logic [11:0] wflags_q, wflags_d;
  logic [4:0]  rem_q, rem_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] result_q, result_d;
  logic [11:0] flags_res_q, flags_res_d;

  logic [4:0]  cnt_c;
  logic [4:0]  iter;
  logic        cf_out;
  logic [11:0] step_flags;
  logic [11:0] fin_flags;
  logic        unused_count;

  assign cnt_c        = count[4:0] & CNT_MASK;
  assign unused_count = ^count[7:5];

`ifdef ALU_SHIFT_SEQ_ROTRED_EN
  logic [4:0] cnt_m1;
  assign cnt_m1 = cnt_c - 5'd1;

  // Rotates repeat with period width (ROL/ROR) or width+1 (RCL/RCR, CF included).
  always_comb begin
    iter = cnt_c;
    if (!op[2] && (cnt_c != 5'd0)) begin
      unique case ({op[1], bit16})
        2'b00:   iter = (cnt_m1 % 5'd8) + 5'd1;
        2'b01:   iter = (cnt_m1 % 5'd16) + 5'd1;
        2'b10:   iter = (cnt_m1 % 5'd9) + 5'd1;
        default: iter = (cnt_m1 % 5'd17) + 5'd1;
      endcase
    end
  end
`else
  assign iter = cnt_c;
`endif

  // Even ops shift left and lose the MSB; odd ops shift right and lose bit 0.
  assign cf_out = op_q[0] ? work_q[0] : msb_sel(work_q, bit16_q);

  always_comb begin
    step_flags          = wflags_q;
    step_flags[FLAG_CF] = cf_out;
  end

  alu_shift_flags u_flags (
    .op_i    (op_q),
    .bit16_i (bit16_q),
    .pre_i   (work_q),
    .post_i  (alu_value),
    .cf_i    (cf_out),
    .flags_i (wflags_q),
    .flags_o (fin_flags)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bit16_d     = bit16_q;
    work_d      = work_q;
    wflags_d    = wflags_q;
    rem_d       = rem_q;
    sel_d       = sel_q;
    result_d    = result_q;
    flags_res_d = flags_res_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = op;
          bit16_d  = bit16;
          work_d   = op1_in;
          wflags_d = flags_in;
          sel_d    = {1'b1, op};
          rem_d    = iter;
          if (cnt_c == 5'd0) begin
            result_d    = op1_in;
            flags_res_d = flags_in;
            state_d     = StFin;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        work_d   = alu_value;
        wflags_d = step_flags;
        rem_d    = rem_q - 5'd1;
        if (rem_q == 5'd1) begin
          result_d    = alu_value;
          flags_res_d = fin_flags;
          state_d     = StFin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 3'd0;
      bit16_q     <= 1'b0;
      work_q      <= 16'h0000;
      wflags_q    <= 12'h000;
      rem_q       <= 5'd0;
      sel_q       <= 4'h0;
      result_q    <= 16'h0000;
      flags_res_q <= 12'h000;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      bit16_q     <= bit16_d;
      work_q      <= work_d;
      wflags_q    <= wflags_d;
      rem_q       <= rem_d;
      sel_q       <= sel_d;
      result_q    <= result_d;
      flags_res_q <= flags_res_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StFin);
  assign result    = result_q;
  assign flags_res = flags_res_q;
  assign alu_busy  = busy;
  assign alu_sel   = sel_q;
  assign alu_op1   = work_q;
  assign alu_bit16 = bit16_q;
  assign alu_flags = wflags_q;

endmodule
